restador_bcd_serial: RTL and testbench
======================================

Name: restador_bcd_serial

Overview:
- Digit-serial multi-digit BCD subtractor: computes |A - B| by adding the 9's complement of B, then applying the end-around carry or re-complementing the sum.
- It is the consumer end of the 9's-complement digit path. It takes complemented digits and turns them back into a signed-magnitude BCD result.
- Sits between operand registers and the BCD display/accumulator path; start/ready handshake in, one-cycle valid pulse out.

Parameters:
- DIGITOS, 4, number of BCD digits per operand (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- inicio  input  1  start request; accepted when inicio && listo.
- listo  output  1  high only in REPOSO.
- A  input  4*DIGITOS  minuend, digit 0 = bits [3:0] (LSD).
- B  input  4*DIGITOS  subtrahend, same layout.
- resultado  output  4*DIGITOS  BCD magnitude |A-B|.
- negativo  output  1  1 when A<B.
- error  output  1  1 when any input digit >9 at accept.
- valido  output  1  one-cycle pulse: resultado/negativo/error are final.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: state=REPOSO, listo=1, resultado=0, negativo=0, error=0, valido=0, internal carry/digit index=0. Reset mid-operation aborts: next cycle REPOSO, no valido.
- Accept edge: A, B latched; inicio ignored when listo=0. If any digit of A or B >9: error=1, resultado=0, negativo=0, go to FIN.
- SUMA, DIGITOS cycles, LSD first:
  - Per digit: s = A[i] + (9 - B[i]) + c.
  - If s>9: digit = s+6 (mod 16), c=1; else digit = s, c=0.
  - c starts at 0.
- CORRECCION, DIGITOS cycles, LSD first:
  - If final SUMA carry=1 (A>=B): add end-around 1, rippling BCD carry; any final carry is discarded; negativo=0.
  - If carry=0 (A<B): each digit replaced by 9-digit; negativo=1.
- FIN, 1 cycle: valido=1; next state REPOSO.
- Negative-zero suppression: if magnitude is all zero, negativo=0.
- Latency: valido asserted 2*DIGITOS+1 cycles after the accept edge. Error case: valido asserted 1 cycle after accept.
- resultado, negativo and error hold until the next accept; error clears on the next valid accept.
- inicio held continuously: a new accept occurs in the REPOSO cycle following FIN (back-to-back throughput 2*DIGITOS+2).

Optional Feature:
- Macro RESTADOR_MODO_SUMA_EN.
- Defined:
  - Adds input port modo (1 bit), latched at accept.
  - modo=1: SUMA uses B[i] uncomplemented (A+B); CORRECCION passes digits unchanged; negativo=0; error additionally set on final carry (overflow), resultado holds the low DIGITOS digits.
  - Latency unchanged.
- Undefined: no modo port; subtract only.

Decomposition:
- Package restador_bcd_pkg:
  - State enum {REPOSO, SUMA, CORRECCION, FIN}.
  - Constants NUEVE=4'd9, SEIS=4'd6.
  - Function comp9(digit) returning 9-digit.
  - Function bcd_valido(digit).
- Sub-module sumador_bcd_digito: combinational 4-bit BCD digit adder (a, b, cin -> s, cout). It is instantiated once and shared by SUMA and CORRECCION.

Test Plan:
- DIGITOS=4, A=0752, B=0321 -> resultado=0431, negativo=0, error=0, valido exactly 9 cycles after accept.
- A=0321, B=0752 -> resultado=0431, negativo=1.
- A=B=5555 -> resultado=0000, negativo=0; A=0000, B=9999 -> resultado=9999, negativo=1.
- A=1A00 (invalid digit) -> error=1, resultado=0000, valido 1 cycle after accept; next accept with A=0002, B=0001 -> error=0, resultado=0001.
- inicio pulsed during SUMA is ignored (listo=0). reset asserted during CORRECCION -> listo=1 next cycle, valido never pulses, outputs=0.
- With RESTADOR_MODO_SUMA_EN, modo=1: A=0999, B=0001 -> resultado=1000, error=0; A=9999, B=0001 -> resultado=0000, error=1.

Source files
------------

// File: rtl/restador_bcd_pkg.sv
// restador_bcd_pkg: shared states, BCD constants and digit helpers for restador_bcd_serial
package restador_bcd_pkg;

   typedef enum logic [1:0] {REPOSO, SUMA, CORRECCION, FIN} estado_t;

   localparam logic [3:0] NUEVE = 4'd9;
   localparam logic [3:0] SEIS  = 4'd6;

   function automatic logic [3:0] comp9(input logic [3:0] d);
      return NUEVE - d;
   endfunction

   function automatic logic bcd_valido(input logic [3:0] d);
      return d <= NUEVE;
   endfunction

endpackage

// File: rtl/sumador_bcd_digito.sv
// sumador_bcd_digito: combinational single-digit BCD adder with carry in/out
module sumador_bcd_digito
   import restador_bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [4:0] t;
   // binary sum, then +6 correction whenever the result leaves the decimal range
   always_comb begin
      t = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      cout = t > {1'b0, NUEVE};
      s = cout ? t[3:0] + SEIS : t[3:0];
   end
endmodule

// File: rtl/restador_bcd_serial.sv
// restador_bcd_serial: digit-serial |A-B| BCD subtractor; macro RESTADOR_MODO_SUMA_EN adds port modo for A+B
module restador_bcd_serial
   import restador_bcd_pkg::*;
#(
   parameter int DIGITOS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   inicio,
`ifdef RESTADOR_MODO_SUMA_EN
   input  logic                   modo,
`endif
   output logic                   listo,
   input  logic [4*DIGITOS-1:0]   A,
   input  logic [4*DIGITOS-1:0]   B,
   output logic [4*DIGITOS-1:0]   resultado,
   output logic                   negativo,
   output logic                   error,
   output logic                   valido
);
   localparam int W  = 4 * DIGITOS;
   localparam int IW = DIGITOS > 1 ? $clog2(DIGITOS) : 1;

   estado_t       estado;
   logic [IW-1:0] idx;
   logic          c, cf, md, ok, si, so, ultimo;
   logic [W-1:0]  w, rb;
   logic [3:0]    sb, ss, d;

`ifdef RESTADOR_MODO_SUMA_EN
   // operation mode is captured with the operands so it stays stable for the whole run
   always_ff @(posedge clk) begin
      if (reset) md <= 1'b0;
      else if (estado == REPOSO && inicio) md <= modo;
   end
`else
   assign md = 1'b0;
`endif

   // every digit of both operands must be decimal for the run to proceed
   always_comb begin
      ok = 1'b1;
      for (int i = 0; i < DIGITOS; i++) ok &= bcd_valido(A[4*i +: 4]) & bcd_valido(B[4*i +: 4]);
   end

   // digit path: SUMA adds the (complemented) B digit, CORRECCION ripples the end-around
   // carry or re-complements; the working register rotates so the active digit is always [3:0]
   always_comb begin
      sb = (estado == SUMA) ? (md ? rb[3:0] : comp9(rb[3:0])) : 4'd0;
      si = c;
      d = (estado == CORRECCION && !cf && !md) ? comp9(w[3:0]) : ss;
      ultimo = idx == IW'(DIGITOS - 1);
   end

   sumador_bcd_digito u_dig (
      .a    (w[3:0]),
      .b    (sb),
      .cin  (si),
      .s    (ss),
      .cout (so)
   );

   // control FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         estado    <= REPOSO;
         listo     <= 1'b1;
         resultado <= '0;
         negativo  <= 1'b0;
         error     <= 1'b0;
         valido    <= 1'b0;
         idx       <= '0;
         c         <= 1'b0;
         cf        <= 1'b0;
         w         <= '0;
         rb        <= '0;
      end else begin
         valido <= 1'b0;
         case (estado)
            REPOSO: if (inicio) begin
               w      <= A;
               rb     <= B;
               idx    <= '0;
               c      <= 1'b0;
               listo  <= 1'b0;
               error  <= ~ok;
               estado <= ok ? SUMA : FIN;
               if (!ok) begin
                  resultado <= '0;
                  negativo  <= 1'b0;
               end
            end
            SUMA: begin
               w   <= (w >> 4) | (W'(d) << (W - 4));
               rb  <= rb >> 4;
               c   <= so;
               idx <= idx + 1'b1;
               if (ultimo) begin
                  idx    <= '0;
                  cf     <= so;
                  c      <= so & ~md;
                  estado <= CORRECCION;
               end
            end
            CORRECCION: begin
               w   <= (w >> 4) | (W'(d) << (W - 4));
               c   <= so;
               idx <= idx + 1'b1;
               if (ultimo) begin
                  idx    <= '0;
                  estado <= FIN;
               end
            end
            FIN: begin
               valido <= 1'b1;
               listo  <= 1'b1;
               estado <= REPOSO;
               if (!error) begin
                  resultado <= w;
                  negativo  <= ~cf & ~md & (|w);
                  error     <= cf & md;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_restador_bcd_serial.sv
// tb_restador_bcd_serial: directed self-checking bench for restador_bcd_serial (DIGITOS=4)
module tb_restador_bcd_serial;
   logic clk = 1'b0;
   logic reset, inicio, modo;
   logic [15:0] A, B, resultado;
   logic listo, negativo, error, valido;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   restador_bcd_serial #(.DIGITOS(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .inicio    (inicio),
`ifdef RESTADOR_MODO_SUMA_EN
      .modo      (modo),
`endif
      .listo     (listo),
      .A         (A),
      .B         (B),
      .resultado (resultado),
      .negativo  (negativo),
      .error     (error),
      .valido    (valido)
   );

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic m, output int lat);
      @(negedge clk);
      A = a; B = b; modo = m; inicio = 1'b1;
      @(posedge clk);
      #1 inicio = 1'b0;
      lat = 0;
      while (!valido && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      if (!valido) begin
         total++; bad++;
         $display("FAIL op_timeout a=%h b=%h no valido after %0d cycles", a, b, lat);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; inicio = 1'b0; A = '0; B = '0; modo = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (listo !== 1'b1) begin bad++; $display("FAIL rst_listo got=%b exp=1", listo); end
      total++; if (resultado !== 16'h0000) begin bad++; $display("FAIL rst_res got=%h exp=0000", resultado); end
      total++; if ({negativo, error, valido} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {negativo, error, valido}); end
      @(negedge clk) reset = 1'b0;
   endtask

   task automatic test_sub_pos;
      int lat;
      do_op(16'h0752, 16'h0321, 1'b0, lat);
      total++; if (resultado !== 16'h0431) begin bad++; $display("FAIL pos_res got=%h exp=0431", resultado); end
      total++; if ({negativo, error} !== 2'b00) begin bad++; $display("FAIL pos_flags got=%b exp=00", {negativo, error}); end
      total++; if (lat !== 9) begin bad++; $display("FAIL pos_latency got=%0d exp=9", lat); end
      @(posedge clk); #1;
      total++; if (valido !== 1'b0) begin bad++; $display("FAIL pos_pulse_width got=%b exp=0", valido); end
   endtask

   task automatic test_sub_neg;
      int lat;
      do_op(16'h0321, 16'h0752, 1'b0, lat);
      total++; if (resultado !== 16'h0431) begin bad++; $display("FAIL neg_res got=%h exp=0431", resultado); end
      total++; if ({negativo, error} !== 2'b10) begin bad++; $display("FAIL neg_flags got=%b exp=10", {negativo, error}); end
   endtask

   task automatic test_limits;
      int lat;
      do_op(16'h5555, 16'h5555, 1'b0, lat);
      total++; if (resultado !== 16'h0000) begin bad++; $display("FAIL eq_res got=%h exp=0000", resultado); end
      total++; if (negativo !== 1'b0) begin bad++; $display("FAIL eq_neg got=%b exp=0", negativo); end
      do_op(16'h0000, 16'h9999, 1'b0, lat);
      total++; if (resultado !== 16'h9999) begin bad++; $display("FAIL max_res got=%h exp=9999", resultado); end
      total++; if (negativo !== 1'b1) begin bad++; $display("FAIL max_neg got=%b exp=1", negativo); end
   endtask

   task automatic test_error;
      int lat;
      do_op(16'h1A00, 16'h0000, 1'b0, lat);
      total++; if (error !== 1'b1) begin bad++; $display("FAIL err_flag got=%b exp=1", error); end
      total++; if ({resultado, negativo} !== 17'h0) begin bad++; $display("FAIL err_res got=%h/%b exp=0000/0", resultado, negativo); end
      total++; if (lat !== 1) begin bad++; $display("FAIL err_latency got=%0d exp=1", lat); end
      do_op(16'h0002, 16'h0001, 1'b0, lat);
      total++; if (error !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", error); end
      total++; if (resultado !== 16'h0001) begin bad++; $display("FAIL err_next_res got=%h exp=0001", resultado); end
   endtask

   task automatic test_inicio_ignored;
      int lat;
      @(negedge clk);
      A = 16'h0321; B = 16'h0752; modo = 1'b0; inicio = 1'b1;
      @(posedge clk);
      #1 inicio = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (listo !== 1'b0) begin bad++; $display("FAIL busy_listo got=%b exp=0", listo); end
      A = 16'h0999; B = 16'h0000; inicio = 1'b1;
      @(posedge clk);
      #1 inicio = 1'b0;
      lat = 3;
      while (!valido && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      total++; if (lat !== 9) begin bad++; $display("FAIL busy_latency got=%0d exp=9", lat); end
      total++; if ({resultado, negativo} !== {16'h0431, 1'b1}) begin bad++; $display("FAIL busy_res got=%h/%b exp=0431/1", resultado, negativo); end
   endtask

   task automatic test_reset_mid;
      int seen;
      @(negedge clk);
      A = 16'h0321; B = 16'h0752; inicio = 1'b1;
      @(posedge clk);
      #1 inicio = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      total++; if (listo !== 1'b1) begin bad++; $display("FAIL abort_listo got=%b exp=1", listo); end
      total++; if ({resultado, negativo, error, valido} !== 19'h0) begin bad++; $display("FAIL abort_outs got=%h/%b%b%b exp=0000/000", resultado, negativo, error, valido); end
      @(negedge clk) reset = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1 if (valido) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL abort_valido got=%0d pulses exp=0", seen); end
   endtask

   task automatic test_back_to_back;
      int n;
      @(negedge clk);
      A = 16'h0002; B = 16'h0001; modo = 1'b0; inicio = 1'b1;
      n = 0;
      while (!valido && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (!valido && n < 40);
      inicio = 1'b0;
      total++; if (n !== 10) begin bad++; $display("FAIL b2b_period got=%0d exp=10", n); end
      total++; if (resultado !== 16'h0001) begin bad++; $display("FAIL b2b_res got=%h exp=0001", resultado); end
      repeat (2) @(posedge clk);
   endtask

`ifdef RESTADOR_MODO_SUMA_EN
   task automatic test_modo;
      int lat;
      do_op(16'h0999, 16'h0001, 1'b1, lat);
      total++; if ({resultado, negativo, error} !== {16'h1000, 2'b00}) begin bad++; $display("FAIL add_res got=%h/%b%b exp=1000/00", resultado, negativo, error); end
      total++; if (lat !== 9) begin bad++; $display("FAIL add_latency got=%0d exp=9", lat); end
      do_op(16'h9999, 16'h0001, 1'b1, lat);
      total++; if ({resultado, negativo, error} !== {16'h0000, 2'b01}) begin bad++; $display("FAIL add_ovf got=%h/%b%b exp=0000/01", resultado, negativo, error); end
   endtask
`endif

   initial begin
      test_reset;
      test_sub_pos;
      test_sub_neg;
      test_limits;
      test_error;
      test_inicio_ignored;
      test_reset_mid;
      test_back_to_back;
`ifdef RESTADOR_MODO_SUMA_EN
      test_modo;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
